// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared gate-state encoding and width helpers for the parking zone controller
package parking_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } gate_state_e;

    // Bits needed to index n items; never below 1 so single-zone builds stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold values 0..v inclusive.
    function automatic int val_width(input int v);
        return (v > 0) ? $clog2(v + 1) : 1;
    endfunction

endpackage

// File: rtl/zone_counter.sv
// rtl/zone_counter.sv - saturating per-zone occupancy counter with sticky underflow flag
module zone_counter
    import parking_pkg::*;
#(
    parameter int ZONE_CAP = 20,
    parameter int AF_FREE  = 2,
    parameter int CW       = val_width(ZONE_CAP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          reserved_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          afull_o,
    output logic          underflow_o
);

    localparam logic [CW-1:0] CAP = CW'(ZONE_CAP);

    logic [CW-1:0] count_q, count_d;
    logic          uf_q, uf_d;
    logic [CW:0]   occ;
    logic [CW:0]   free_sp;

    always_comb begin
        count_d = count_q;
        uf_d    = uf_q;
        unique case ({inc_i, dec_i})
            2'b10: begin
                if (count_q != CAP) count_d = count_q + 1'b1;
            end
            2'b01: begin
                if (count_q != '0) count_d = count_q - 1'b1;
                else               uf_d    = 1'b1;
            end
            // Commit and exit together cancel: the exit sees the committed car, so no underflow.
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            uf_q    <= uf_d;
        end
    end

    // A reservation is only ever granted into a non-full zone, so occ never exceeds CAP.
    always_comb begin
        occ     = {1'b0, count_q} + {{CW{1'b0}}, reserved_i};
        free_sp = {1'b0, CAP} - occ;
    end

    assign count_o     = count_q;
    assign full_o      = (occ == {1'b0, CAP});
    assign afull_o     = (int'(free_sp) <= AF_FREE);
    assign underflow_o = uf_q;

endmodule

// File: rtl/parking_zone_ctrl.sv
// rtl/parking_zone_ctrl.sv - multi-zone parking entry gate FSM with per-zone occupancy tracking
module parking_zone_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_ZONES    = 4,
    parameter int ZONE_CAP     = 20,
    parameter int AF_FREE      = 2,
    parameter int GATE_TIMEOUT = 100,
    localparam int ZW          = idx_width(NUM_ZONES),
    localparam int CW          = val_width(ZONE_CAP),
    localparam int TW          = val_width(NUM_ZONES * ZONE_CAP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    entry_req,
    input  logic [ZW-1:0]           entry_zone,
    input  logic                    car_passed,
    input  logic [NUM_ZONES-1:0]    exit_pulse,
    output logic                    gate_open,
    output logic                    entry_grant,
    output logic                    entry_reject,
    output logic                    gate_timeout,
    output logic [NUM_ZONES*CW-1:0] count,
    output logic [NUM_ZONES-1:0]    zone_full,
    output logic [NUM_ZONES-1:0]    zone_afull,
    output logic [TW-1:0]           total_count,
    output logic                    lot_full,
    output logic [NUM_ZONES-1:0]    err_underflow
);

    localparam int TMW = val_width(GATE_TIMEOUT);
    localparam logic [TMW-1:0] TMR_LAST = TMW'(GATE_TIMEOUT - 1);

    gate_state_e         state_q, state_d;
    logic [ZW-1:0]       zone_q, zone_d;
    logic [TMW-1:0]      tmr_q, tmr_d;
    logic                grant_q, grant_d;
    logic                reject_q, reject_d;
    logic                timeout_q, timeout_d;
    logic                commit;

    logic [NUM_ZONES-1:0] inc;
    logic [NUM_ZONES-1:0] reserved;
    logic [(2**ZW)-1:0]   full_pad;
    logic                 req_valid;
    logic [CW-1:0]        cnt [NUM_ZONES];

    // Zero-pad so an out-of-range entry_zone can never index past the real zones.
    always_comb begin
        full_pad                = '0;
        full_pad[NUM_ZONES-1:0] = zone_full;
        req_valid               = (int'(entry_zone) < NUM_ZONES);
    end

    always_comb begin
        state_d   = state_q;
        zone_d    = zone_q;
        tmr_d     = tmr_q;
        grant_d   = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (entry_req) begin
                    if (req_valid && !full_pad[entry_zone]) begin
                        state_d = OPEN;
                        zone_d  = entry_zone;
                        tmr_d   = '0;
                        grant_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (car_passed) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            zone_q    <= '0;
            tmr_q     <= '0;
            grant_q   <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            zone_q    <= zone_d;
            tmr_q     <= tmr_d;
            grant_q   <= grant_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        inc      = '0;
        reserved = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            reserved[z] = (state_q == OPEN) && (zone_q == ZW'(z));
            inc[z]      = commit && (zone_q == ZW'(z));
        end
    end

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
        zone_counter #(
            .ZONE_CAP (ZONE_CAP),
            .AF_FREE  (AF_FREE),
            .CW       (CW)
        ) u_zone (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc[g]),
            .dec_i       (exit_pulse[g]),
            .reserved_i  (reserved[g]),
            .count_o     (cnt[g]),
            .full_o      (zone_full[g]),
            .afull_o     (zone_afull[g]),
            .underflow_o (err_underflow[g])
        );
        assign count[g*CW +: CW] = cnt[g];
    end

    always_comb begin
        total_count = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            total_count = total_count + TW'(cnt[z]);
        end
    end

    assign lot_full     = &zone_full;
    assign gate_open    = (state_q == OPEN);
    assign entry_grant  = grant_q;
    assign entry_reject = reject_q;
    assign gate_timeout = timeout_q;

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// tb/tb_parking_zone_ctrl.sv - directed self-checking bench for parking_zone_ctrl
module tb_parking_zone_ctrl;

    localparam int NZ = 4;
    localparam int CAP = 3;
    localparam int AF = 1;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          entry_req;
    logic [1:0]    entry_zone;
    logic          car_passed;
    logic [NZ-1:0] exit_pulse;
    logic          gate_open;
    logic          entry_grant;
    logic          entry_reject;
    logic          gate_timeout;
    logic [7:0]    count;
    logic [NZ-1:0] zone_full;
    logic [NZ-1:0] zone_afull;
    logic [3:0]    total_count;
    logic          lot_full;
    logic [NZ-1:0] err_underflow;

    int checks = 0;
    int errors = 0;

    parking_zone_ctrl #(
        .NUM_ZONES    (NZ),
        .ZONE_CAP     (CAP),
        .AF_FREE      (AF),
        .GATE_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .entry_req     (entry_req),
        .entry_zone    (entry_zone),
        .car_passed    (car_passed),
        .exit_pulse    (exit_pulse),
        .gate_open     (gate_open),
        .entry_grant   (entry_grant),
        .entry_reject  (entry_reject),
        .gate_timeout  (gate_timeout),
        .count         (count),
        .zone_full     (zone_full),
        .zone_afull    (zone_afull),
        .total_count   (total_count),
        .lot_full      (lot_full),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cnt(input int z);
        return count[z*2 +: 2];
    endfunction

    task automatic enter(input logic [1:0] z);
        entry_req  = 1'b1;
        entry_zone = z;
        step();
        entry_req  = 1'b0;
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        entry_req  = 1'b0;
        entry_zone = 2'd0;
        car_passed = 1'b0;
        exit_pulse = '0;
        step();
        step();
        chk("rst_gate_open", gate_open, 0);
        chk("rst_pulses", {entry_grant, entry_reject, gate_timeout}, 0);
        chk("rst_count", count, 0);
        chk("rst_full", zone_full, 0);
        chk("rst_afull", zone_afull, 0);
        chk("rst_total", total_count, 0);
        chk("rst_lot_full", lot_full, 0);
        chk("rst_err", err_underflow, 0);
        rst = 1'b0;
        step();

        // Fill zone 2 to capacity, then get turned away
        entry_req  = 1'b1;
        entry_zone = 2'd2;
        step();
        entry_req = 1'b0;
        chk("grant_first", entry_grant, 1);
        chk("open_first", gate_open, 1);
        chk("afull_z2_reserved", zone_afull[2], 0);
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        chk("cnt2_one", cnt(2), 1);
        chk("closed_after_pass", gate_open, 0);
        enter(2'd2);
        chk("cnt2_two", cnt(2), 2);
        chk("afull_z2_two", zone_afull[2], 1);
        chk("full_z2_two", zone_full[2], 0);
        enter(2'd2);
        chk("cnt2_full", cnt(2), 3);
        chk("full_z2", zone_full[2], 1);
        entry_req  = 1'b1;
        entry_zone = 2'd2;
        step();
        entry_req = 1'b0;
        chk("reject_full", entry_reject, 1);
        chk("reject_no_grant", entry_grant, 0);
        chk("reject_gate_closed", gate_open, 0);
        step();
        chk("reject_one_cycle", entry_reject, 0);

        // Zone 1 gate times out after 8 open cycles; an entry_req while open is ignored
        entry_req  = 1'b1;
        entry_zone = 2'd1;
        step();
        chk("z1_grant", entry_grant, 1);
        chk("z1_open_c1", gate_open, 1);
        chk("z1_full_reserved", zone_full[1], 0);
        entry_zone = 2'd0;
        step();
        entry_req = 1'b0;
        chk("open_req_ignored", {entry_grant, entry_reject}, 0);
        chk("z1_open_c2", gate_open, 1);
        for (int i = 3; i <= TMO; i++) begin
            step();
            chk("z1_open_hold", gate_open, 1);
        end
        step();
        chk("z1_timeout_closed", gate_open, 0);
        chk("z1_timeout_pulse", gate_timeout, 1);
        chk("z1_cnt", cnt(1), 0);
        chk("z1_full_restore", zone_full[1], 0);
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        chk("timeout_one_cycle", gate_timeout, 0);
        chk("idle_pass_ignored", total_count, 3);

        // Commit and exit in the same zone, same cycle
        enter(2'd0);
        enter(2'd0);
        chk("cnt0_two", cnt(0), 2);
        entry_req  = 1'b1;
        entry_zone = 2'd0;
        step();
        entry_req = 1'b0;
        chk("z0_full_reserved", zone_full[0], 1);
        car_passed = 1'b1;
        exit_pulse = 4'b0001;
        step();
        car_passed = 1'b0;
        exit_pulse = '0;
        chk("commit_exit_cnt0", cnt(0), 2);
        chk("commit_exit_idle", gate_open, 0);
        chk("commit_exit_no_err", err_underflow, 0);

        // Underflow on empty zone 3, then simultaneous exits on zones 0 and 2
        exit_pulse = 4'b1000;
        step();
        exit_pulse = '0;
        chk("uf_cnt3", cnt(3), 0);
        chk("uf_flag", err_underflow, 4'b1000);
        exit_pulse = 4'b0101;
        step();
        exit_pulse = '0;
        chk("multi_exit_cnt0", cnt(0), 1);
        chk("multi_exit_cnt2", cnt(2), 2);
        chk("multi_exit_total", total_count, 3);
        chk("uf_sticky", err_underflow, 4'b1000);

        // Fill the whole lot
        enter(2'd0);
        enter(2'd0);
        enter(2'd1);
        enter(2'd1);
        enter(2'd1);
        enter(2'd2);
        enter(2'd3);
        enter(2'd3);
        enter(2'd3);
        chk("lot_total", total_count, 12);
        chk("lot_full", lot_full, 1);
        chk("lot_zone_full", zone_full, 4'hF);
        chk("lot_afull", zone_afull, 4'hF);
        chk("uf_sticky_late", err_underflow, 4'b1000);
        entry_req  = 1'b1;
        entry_zone = 2'(5);
        step();
        entry_req = 1'b0;
        chk("zone5_reject", entry_reject, 1);
        chk("zone5_closed", gate_open, 0);

        // Reset while the gate is open on zone 2
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", count, 0);
        chk("rst2_err", err_underflow, 0);
        enter(2'd2);
        entry_req  = 1'b1;
        entry_zone = 2'd2;
        step();
        entry_req = 1'b0;
        chk("pre_rst_open", gate_open, 1);
        chk("pre_rst_cnt2", cnt(2), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_open_closed", gate_open, 0);
        chk("rst_open_count", count, 0);
        chk("rst_open_total", total_count, 0);
        chk("rst_open_pulses", {entry_grant, entry_reject, gate_timeout}, 0);
        chk("rst_open_full", zone_full, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
